// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: handshake state encoding and
// default address/data widths.
package mem_pkg;

  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESP    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/ram_sp.sv
// Single-port word array: synchronous write, combinational read, no reset,
// so contents survive a responder reset.
module ram_sp #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the MDR read/write interface: 4-phase handshake,
// programmable wait states, one access per request regardless of hold time.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clock,
  input  logic              clear,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] Wdata,
  output logic [DATA_W-1:0] Mdatain,
  output logic              Done,
  output logic              Busy,
  output logic              ProtErr
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                opWrite_q, opWrite_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   mdat_q, mdat_d;
  logic                done_q, done_d;
  logic                protErr_q, protErr_d;
  logic                enterResp;
  logic                reqLine;
  logic                ramWe;
  logic [DATA_W-1:0]   ramRdata;

  assign reqLine = opWrite_q ? Write : Read;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opWrite_d = opWrite_q;
    addr_d    = addr_q;
    data_d    = data_q;
    protErr_d = 1'b0;
    enterResp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Read && Write) begin
          protErr_d = 1'b1;
        end else if (Read || Write) begin
          opWrite_d = Write;
          addr_d    = Addr;
          data_d    = Wdata;
          cnt_d     = WAIT_LOAD;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
          end else begin
            state_d   = S_RESP;
            enterResp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = S_RESP;
          enterResp = 1'b1;
        end
      end
      S_RESP: begin
        // Done must have been visible for at least one cycle before release
        if (done_q && !reqLine) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!Read && !Write) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The *_d copies carry live inputs on a zero-wait accept, latched values otherwise.
  assign ramWe  = enterResp && opWrite_d;
  assign mdat_d = (enterResp && !opWrite_d) ? ramRdata : mdat_q;
  assign done_d = (state_q == S_RESP) && (state_d == S_RESP);

  ram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (Clock),
    .we_i    (ramWe),
    .addr_i  (addr_d),
    .wdata_i (data_d),
    .rdata_o (ramRdata)
  );

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      opWrite_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      mdat_q    <= '0;
      done_q    <= 1'b0;
      protErr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opWrite_q <= opWrite_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      mdat_q    <= mdat_d;
      done_q    <= done_d;
      protErr_q <= protErr_d;
    end
  end

  assign Mdatain = mdat_q;
  assign Done    = done_q;
  assign Busy    = (state_q != S_IDLE);
  assign ProtErr = protErr_q;

endmodule
